vec3_alu_pipe: RTL and testbench
================================

# vec3_alu_pipe

Pipelined, parametrised fixed-point vec3 arithmetic unit for the ray marcher. It accepts one vec3 operation per cycle over a valid/ready handshake: add, sub, neg, dot, scale or multiply-add. It returns results in order after a fixed 3-cycle latency, with optional saturation and a per-result overflow flag. It sits between the march-step sequencer and the SDF evaluation stages and replaces ad-hoc combinational vector functions on timing-critical paths.

## Interface
- DATA_WIDTH, 32, signed fixed-point element width (W), 8..32
- FRAC_BITS, 16, fractional bits of every element and scalar, < W
- SATURATE, 1, 1 = clamp results to the signed W range; 0 = two's-complement wrap
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operation
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  3  0 ADD, 1 SUB, 2 NEG, 3 DOT, 4 SCALE, 5 MADD, 6..7 illegal
- in_a  in  3W  vec3 {z,y,x}, x in LSBs
- in_b  in  3W  vec3 {z,y,x}
- in_s  in  W  scalar for SCALE/MADD
- in_tag  in  TAG_WIDTH  returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_res  out  3W  vec3 result; DOT puts the scalar in x, and y = z = 0
- out_tag  out  TAG_WIDTH  tag of this result
- out_ovf  out  1  any element saturated or wrapped
- out_err  out  1  illegal opcode; out_res = 0

## Operation
- ADD: a+b per element. SUB: a−b. NEG: −a. SCALE: a·s. MADD: a·s + b. DOT: a.x·b.x + a.y·b.y + a.z·b.z.
- Multiply: full 2W signed product, arithmetic shift right by FRAC_BITS (floor toward −∞), kept at W+2 bits before final add/clamp.
- DOT sums three shifted products at W+2 bits; overflow is evaluated only on the final sum.
- Final stage behaviour, per element:
  - SATURATE=1: clamp to [−2^(W−1), 2^(W−1)−1], and set out_ovf if any clamp occurred.
  - SATURATE=0: truncate to W bits, and set out_ovf if the truncated value ≠ the wide value.
- NEG of −2^(W−1): with SATURATE=1 the result is 2^(W−1)−1 with ovf=1; with SATURATE=0 the result is −2^(W−1) with ovf=1.
- Illegal opcode: the operation flows through the pipe normally, with out_res=0, out_err=1, out_ovf=0.
- Pipeline stages:
  - S1 registers operands and the 2W products.
  - S2 shifts and forms the W+2 partial sums.
  - S3 does the final add, clamp/truncate and flags.
- Each stage holds a valid bit. The tag and opcode travel with the data.

## Timing
- Latency: an operation accepted at edge N appears on out_* during the cycle after edge N+3 (3 register stages), absent stalls.
- Throughput: 1 operation/cycle when out_ready=1.
- in_ready = !(S3.valid && !out_ready). This is global-stall backpressure: all stages advance together or hold. The bubble-collapse optimisation is not required.
- A transfer occurs when in_valid && in_ready, or when out_valid && out_ready, at the rising edge.
- While stalled, out_res, out_tag, out_ovf and out_err are held stable and out_valid stays 1.
- Simultaneous output pop and input push in the same cycle is legal, and no cycle is lost.
- Reset, asserted asynchronously:
  - All stage valids, out_valid, out_res, out_tag, out_ovf and out_err go to 0 immediately.
  - in_ready=1 while rst is high and after rst is released.
  - In-flight operations are discarded and never emitted.
- First acceptance is possible on the first rising edge after rst deasserts.
- Results are emitted strictly in acceptance order. No reordering and no drops.

## Test plan
- Back-to-back ADD (W=32, F=16): a=(1.0,2.0,−3.0)=(0x00010000,0x00020000,0xFFFD0000), b=(0.5,0.5,0.5) -> out (1.5,2.5,−2.5) = (0x00018000,0x00028000,0xFFFD8000), exactly 3 cycles after acceptance, ovf=0.
- DOT a=(1.0,2.0,3.0), b=(4.0,5.0,6.0) -> x=32.0 (0x00200000), y=z=0. SCALE a=(−1.5,0,0.25), s=2.0 -> (−3.0,0,0.5). MADD a=(1,1,1), s=0.5, b=(1,1,1) -> (1.5,1.5,1.5).
- Saturation: ADD x 0x7FFF0000 + 0x00020000 -> SATURATE=1 gives 0x7FFFFFFF with ovf=1, SATURATE=0 gives 0x80010000 with ovf=1. NEG of x=0x80000000 with SATURATE=1 -> 0x7FFFFFFF, ovf=1.
- Backpressure: 8 ops with tags 0..7 streamed while out_ready toggles randomly, including 5 consecutive low cycles -> in_ready drops within the same cycle as the stall, all 8 results emerge in tag order 0..7, values are held stable during the stall, and none are duplicated or lost.
- Illegal op 6 with tag 0xA -> out_err=1, out_res=0, out_tag=0xA, and the neighbouring valid ops are unaffected.
- Reset mid-flight: 3 ops in the pipe, rst pulsed for 1 cycle between clock edges -> out_valid=0 immediately, no stale results afterwards, and the next op, accepted on the first edge after release, emerges 3 cycles later.

Source files
------------

// File: rtl/vec3_alu_pipe.sv
// vec3_alu_pipe: pipelined fixed-point vec3 ALU (add/sub/neg/dot/scale/madd).
// In-order results with fixed latency, global-stall backpressure and saturate/wrap output.
module vec3_alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int SATURATE   = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [3*DATA_WIDTH-1:0] in_a,
  input  logic [3*DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0]   in_s,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*DATA_WIDTH-1:0] out_res,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_ovf,
  output logic                    out_err
);

  localparam int W = DATA_WIDTH;
  localparam int P = 2 * DATA_WIDTH;
  localparam int E = DATA_WIDTH + 2;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_NEG   = 3'd2;
  localparam logic [2:0] OP_DOT   = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;

  localparam logic [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

  // S1 is two register banks deep (operand capture, then products) so results
  // land on out_* after the third edge following acceptance.
  logic               r_s0_valid;
  logic [2:0]         r_s0_op;
  logic [TAG_WIDTH-1:0] r_s0_tag;
  logic [3*W-1:0]     r_s0_a, r_s0_b;
  logic [W-1:0]       r_s0_s;

  logic               r_s1_valid;
  logic [2:0]         r_s1_op;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [3*W-1:0]     r_s1_a, r_s1_b;
  logic [2:0][P-1:0]  r_s1_prod;

  logic               r_s2_valid;
  logic [2:0]         r_s2_op;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic [2:0][E-1:0]  r_s2_e, r_s2_f;

  logic               r_s3_valid;
  logic [TAG_WIDTH-1:0] r_s3_tag;
  logic [3*W-1:0]     r_s3_res;
  logic               r_s3_ovf, r_s3_err;

  logic               w_adv;
  logic [2:0][P-1:0]  w_prod;
  logic [2:0][E-1:0]  w_sh, w_e, w_f;
  logic [E-1:0]       w_dot_e;
  logic [2:0][W-1:0]  w_res;
  logic [2:0]         w_ovf_el;
  logic               w_s2_err;

  assign w_adv    = !(r_s3_valid && !out_ready);
  assign w_dot_e  = w_sh[0] + w_sh[1];
  assign w_s2_err = (r_s2_op > OP_MADD);

  for (genvar gi = 0; gi < 3; gi++) begin : g_elem
    logic [W-1:0] w_a0, w_rhs, w_a1, w_b1;
    logic [E-1:0] w_ax, w_bx, w_el_e, w_el_f, w_sum;
    logic [2:0]   w_top;

    assign w_a0       = r_s0_a[gi*W +: W];
    assign w_rhs      = (r_s0_op == OP_DOT) ? r_s0_b[gi*W +: W] : r_s0_s;
    assign w_prod[gi] = {{W{w_a0[W-1]}}, w_a0} * {{W{w_rhs[W-1]}}, w_rhs};

    assign w_sh[gi] = E'($signed(r_s1_prod[gi]) >>> FRAC_BITS);
    assign w_a1     = r_s1_a[gi*W +: W];
    assign w_b1     = r_s1_b[gi*W +: W];
    assign w_ax     = {{2{w_a1[W-1]}}, w_a1};
    assign w_bx     = {{2{w_b1[W-1]}}, w_b1};

    always_comb begin
      w_el_e = '0;
      w_el_f = '0;
      case (r_s1_op)
        OP_ADD:   begin w_el_e = w_ax;     w_el_f = w_bx;       end
        OP_SUB:   begin w_el_e = w_ax;     w_el_f = '0 - w_bx;  end
        OP_NEG:   w_el_e = '0 - w_ax;
        OP_DOT:   if (gi == 0) begin w_el_e = w_dot_e; w_el_f = w_sh[2]; end
        OP_SCALE: w_el_e = w_sh[gi];
        OP_MADD:  begin w_el_e = w_sh[gi]; w_el_f = w_bx;       end
        default:  ;
      endcase
    end

    assign w_e[gi] = w_el_e;
    assign w_f[gi] = w_el_f;

    // The wide sum fits W bits only when its top three bits agree.
    assign w_sum        = r_s2_e[gi] + r_s2_f[gi];
    assign w_top        = w_sum[E-1:W-1];
    assign w_ovf_el[gi] = (w_top != 3'b000) && (w_top != 3'b111);
    assign w_res[gi]    = (w_ovf_el[gi] && (SATURATE != 0)) ?
                          (w_sum[E-1] ? W_MIN : W_MAX) : w_sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_op    <= '0;
      r_s0_tag   <= '0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_s     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_prod  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_op    <= '0;
      r_s2_tag   <= '0;
      r_s2_e     <= '0;
      r_s2_f     <= '0;
      r_s3_valid <= 1'b0;
      r_s3_tag   <= '0;
      r_s3_res   <= '0;
      r_s3_ovf   <= 1'b0;
      r_s3_err   <= 1'b0;
    end else if (w_adv) begin
      r_s0_valid <= in_valid;
      r_s0_op    <= in_op;
      r_s0_tag   <= in_tag;
      r_s0_a     <= in_a;
      r_s0_b     <= in_b;
      r_s0_s     <= in_s;
      r_s1_valid <= r_s0_valid;
      r_s1_op    <= r_s0_op;
      r_s1_tag   <= r_s0_tag;
      r_s1_a     <= r_s0_a;
      r_s1_b     <= r_s0_b;
      r_s1_prod  <= w_prod;
      r_s2_valid <= r_s1_valid;
      r_s2_op    <= r_s1_op;
      r_s2_tag   <= r_s1_tag;
      r_s2_e     <= w_e;
      r_s2_f     <= w_f;
      r_s3_valid <= r_s2_valid;
      r_s3_tag   <= r_s2_tag;
      r_s3_res   <= w_s2_err ? '0 : w_res;
      r_s3_ovf   <= !w_s2_err && (|w_ovf_el);
      r_s3_err   <= w_s2_err;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign out_res   = r_s3_res;
  assign out_tag   = r_s3_tag;
  assign out_ovf   = r_s3_ovf;
  assign out_err   = r_s3_err;

endmodule

// File: tb/tb_vec3_alu_pipe.sv
// Bench for vec3_alu_pipe: saturating and wrapping instances share stimulus; a
// negedge scoreboard checks every output transfer, and scenario tasks check timing.
module tb_vec3_alu_pipe;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_NEG = 3'd2,
                         OP_DOT = 3'd3, OP_SCALE = 3'd4, OP_MADD = 3'd5;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = '0;
  logic [95:0] in_a = '0, in_b = '0;
  logic [31:0] in_s = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, out_ovf, out_err;
  logic [95:0] out_res;
  logic [3:0]  out_tag;
  logic        w_in_ready, w_out_valid, w_out_ovf, w_out_err;
  logic [95:0] w_out_res;
  logic [3:0]  w_out_tag;

  typedef struct {
    logic [3:0]  tag;
    logic [95:0] res_sat;
    logic [95:0] res_wrap;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int checks = 0;
  int errors = 0;
  int n_pop  = 0;

  always #5 clk = ~clk;

  vec3_alu_pipe #(.DATA_WIDTH(32), .FRAC_BITS(16), .SATURATE(1), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag), .out_ovf(out_ovf),
    .out_err(out_err));

  vec3_alu_pipe #(.DATA_WIDTH(32), .FRAC_BITS(16), .SATURATE(0), .TAG_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_res(w_out_res), .out_tag(w_out_tag), .out_ovf(w_out_ovf),
    .out_err(w_out_err));

  // ---------------- reference model ----------------
  function automatic longint w34(input longint v);
    logic [63:0] u;
    u = v;
    return {{30{u[33]}}, u[33:0]};
  endfunction

  function automatic longint fmul(input longint x, input longint y);
    return w34((x * y) >>> 16);
  endfunction

  function automatic longint elem(input logic [95:0] v, input int i);
    logic signed [31:0] t;
    t = v[i*32 +: 32];
    return t;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [95:0] a,
                                 input logic [95:0] b, input logic [31:0] s,
                                 input logic [3:0] tag);
    exp_t r;
    longint v, sv;
    logic signed [31:0] ss;
    ss = s;
    sv = ss;
    r.tag = tag;
    r.res_sat = '0;
    r.res_wrap = '0;
    r.ovf = 1'b0;
    r.err = (op > OP_MADD);
    if (!r.err) begin
      for (int i = 0; i < 3; i++) begin
        case (op)
          OP_ADD:   v = elem(a, i) + elem(b, i);
          OP_SUB:   v = elem(a, i) - elem(b, i);
          OP_NEG:   v = -elem(a, i);
          OP_DOT:   v = (i == 0) ? w34(fmul(elem(a, 0), elem(b, 0)) + fmul(elem(a, 1), elem(b, 1))
                                       + fmul(elem(a, 2), elem(b, 2))) : 64'sd0;
          OP_SCALE: v = fmul(elem(a, i), sv);
          default:  v = w34(fmul(elem(a, i), sv) + elem(b, i));
        endcase
        if (v > MAXV) begin
          r.ovf = 1'b1;
          r.res_sat[i*32 +: 32] = 32'h7FFFFFFF;
        end else if (v < MINV) begin
          r.ovf = 1'b1;
          r.res_sat[i*32 +: 32] = 32'h80000000;
        end else begin
          r.res_sat[i*32 +: 32] = v[31:0];
        end
        r.res_wrap[i*32 +: 32] = v[31:0];
      end
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got tag %h with empty queue", out_tag);
        end else begin
          e_pop = sb.pop_front();
          n_pop++;
          if (out_tag !== e_pop.tag || out_res !== e_pop.res_sat || out_ovf !== e_pop.ovf ||
              out_err !== e_pop.err || w_out_valid !== 1'b1 || w_out_tag !== e_pop.tag ||
              w_out_res !== e_pop.res_wrap || w_out_ovf !== e_pop.ovf || w_out_err !== e_pop.err) begin
            errors++;
            $display("FAIL sb_result got tag %h res %h ovf %b err %b wrap %h wovf %b want tag %h res %h ovf %b err %b wrap %h",
                     out_tag, out_res, out_ovf, out_err, w_out_res, w_out_ovf,
                     e_pop.tag, e_pop.res_sat, e_pop.ovf, e_pop.err, e_pop.res_wrap);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b, in_s, in_tag));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] op, input logic [95:0] a, input logic [95:0] b,
                     input logic [31:0] s, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_s = s;
    in_tag = tag;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_res !== 96'h0 || out_tag !== 4'h0 || out_ovf !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid %b res %h tag %h ovf %b err %b want all 0",
               out_valid, out_res, out_tag, out_ovf, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [95:0] a, b, exp_add;
    a = {32'hFFFD0000, 32'h00020000, 32'h00010000};
    b = {32'h00008000, 32'h00008000, 32'h00008000};
    exp_add = {32'hFFFD8000, 32'h00028000, 32'h00018000};
    out_ready = 1'b1;
    put(OP_ADD, a, b, 32'h0, 4'h1);
    tick();
    put(OP_SUB, a, b, 32'h0, 4'h2);
    tick();
    put(OP_NEG, a, b, 32'h0, 4'h3);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early got out_valid %b want 0 two edges after acceptance", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h1 || out_res !== exp_add || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_add got valid %b tag %h res %h ovf %b want 1 1 %h 0",
               out_valid, out_tag, out_res, out_ovf, exp_add);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h2) begin
      errors++;
      $display("FAIL b2b_second got valid %b tag %h want 1 2", out_valid, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h3) begin
      errors++;
      $display("FAIL b2b_third got valid %b tag %h want 1 3", out_valid, out_tag);
    end
    tick();
  endtask

  task automatic test_ops();
    bit ok;
    logic [95:0] exp_v;
    put(OP_DOT, {32'h00030000, 32'h00020000, 32'h00010000},
        {32'h00060000, 32'h00050000, 32'h00040000}, 32'h0, 4'h4);
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    exp_v = {32'h0, 32'h0, 32'h00200000};
    checks++;
    if (!ok || out_res !== exp_v || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL op_dot got ok %b res %h ovf %b want %h 0", ok, out_res, out_ovf, exp_v);
    end
    tick();
    put(OP_SCALE, {32'h00004000, 32'h00000000, 32'hFFFE8000}, 96'h0, 32'h00020000, 4'h5);
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    exp_v = {32'h00008000, 32'h00000000, 32'hFFFD0000};
    checks++;
    if (!ok || out_res !== exp_v) begin
      errors++;
      $display("FAIL op_scale got ok %b res %h want %h", ok, out_res, exp_v);
    end
    tick();
    put(OP_MADD, {3{32'h00010000}}, {3{32'h00010000}}, 32'h00008000, 4'h6);
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    exp_v = {3{32'h00018000}};
    checks++;
    if (!ok || out_res !== exp_v) begin
      errors++;
      $display("FAIL op_madd got ok %b res %h want %h", ok, out_res, exp_v);
    end
    tick();
  endtask

  task automatic test_saturation();
    bit ok;
    put(OP_ADD, {64'h0, 32'h7FFF0000}, {64'h0, 32'h00020000}, 32'h0, 4'h7);
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok || out_res[31:0] !== 32'h7FFFFFFF || out_ovf !== 1'b1 ||
        w_out_res[31:0] !== 32'h80010000 || w_out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_add got sat %h/%b wrap %h/%b want 7fffffff/1 80010000/1",
               out_res[31:0], out_ovf, w_out_res[31:0], w_out_ovf);
    end
    tick();
    put(OP_NEG, {64'h0, 32'h80000000}, 96'h0, 32'h0, 4'h8);
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok || out_res[31:0] !== 32'h7FFFFFFF || out_ovf !== 1'b1 ||
        w_out_res[31:0] !== 32'h80000000 || w_out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg got sat %h/%b wrap %h/%b want 7fffffff/1 80000000/1",
               out_res[31:0], out_ovf, w_out_res[31:0], w_out_ovf);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [95:0] a, b;
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    out_ready = 1'b1;
    put(OP_ADD, a, b, 32'h00010000, 4'h9);
    tick();
    put(3'd6, a, b, 32'h00010000, 4'hA);
    tick();
    put(OP_SUB, a, b, 32'h00010000, 4'hB);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h9 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_before got valid %b tag %h err %b want 1 9 0", out_valid, out_tag, out_err);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hA || out_err !== 1'b1 || out_res !== 96'h0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op got valid %b tag %h err %b res %h ovf %b want 1 a 1 0 0",
               out_valid, out_tag, out_err, out_res, out_ovf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hB || out_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after got valid %b tag %h err %b want 1 b 0", out_valid, out_tag, out_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int k, cyc, pop0;
    bit holding, accepted, exp_rdy;
    logic [95:0] h_res;
    logic [3:0]  h_tag;
    logic        h_ovf, h_err;
    k = 0;
    cyc = 0;
    pop0 = n_pop;
    holding = 1'b0;
    h_res = '0;
    h_tag = '0;
    h_ovf = 1'b0;
    h_err = 1'b0;
    while ((k < 8 || (n_pop - pop0) < 8) && cyc < 100) begin
      if (holding) begin
        checks++;
        if (out_valid !== 1'b1 || out_res !== h_res || out_tag !== h_tag || out_ovf !== h_ovf || out_err !== h_err) begin
          errors++;
          $display("FAIL bp_hold got valid %b tag %h res %h want 1 %h %h", out_valid, out_tag, out_res, h_tag, h_res);
        end
      end
      if (cyc < 4) out_ready = 1'b1;
      else if (cyc < 9) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      if (k < 8) put(3'($urandom_range(0, 5)), {$urandom(), $urandom(), $urandom()},
                     {$urandom(), $urandom(), $urandom()}, $urandom(), 4'(k));
      else in_valid = 1'b0;
      #1;
      exp_rdy = !(out_valid && !out_ready);
      checks++;
      if (in_ready !== exp_rdy || w_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_ready got %b/%b want %b (out_valid %b out_ready %b)",
                 in_ready, w_in_ready, exp_rdy, out_valid, out_ready);
      end
      holding = out_valid && !out_ready;
      h_res = out_res;
      h_tag = out_tag;
      h_ovf = out_ovf;
      h_err = out_err;
      accepted = in_valid && in_ready;
      tick();
      if (accepted) k++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (k != 8 || (n_pop - pop0) != 8) begin
      errors++;
      $display("FAIL bp_count got accepted %0d emitted %0d want 8 8", k, n_pop - pop0);
    end
  endtask

  task automatic test_reset_midflight();
    logic [95:0] a;
    a = {32'h00010000, 32'h00020000, 32'h00030000};
    out_ready = 1'b1;
    put(OP_ADD, a, a, 32'h0, 4'hC);
    tick();
    put(OP_SUB, a, a, 32'h0, 4'hD);
    tick();
    put(OP_NEG, a, a, 32'h0, 4'hE);
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || w_out_valid !== 1'b0 || out_res !== 96'h0 || out_tag !== 4'h0 ||
        out_ovf !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got valid %b res %h tag %h ovf %b err %b ready %b want 0 0 0 0 0 1",
               out_valid, out_res, out_tag, out_ovf, out_err, in_ready);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    put(OP_ADD, a, a, 32'h0, 4'h5);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale got out_valid %b tag %h want 0 at cycle %0d", out_valid, out_tag, i);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h5) begin
      errors++;
      $display("FAIL rst_first_op got valid %b tag %h want 1 5", out_valid, out_tag);
    end
    tick();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain got %0d pending, out_valid %b want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ops();
    test_saturation();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
